// File: rtl/dot_result_writer.sv
// Writes each dot-product result into mem3 as little-endian bytes, one byte per cycle.
// Optional macro DOT_WRITER_WRAP_EN: wrap the write pointer to 0 instead of asserting full.
module dot_result_writer #(
  parameter int DATA_WIDTH      = 8,
  parameter int VECTOR_WIDTH    = 4,
  parameter int RESULT_WIDTH    = 2*DATA_WIDTH + $clog2(VECTOR_WIDTH),
  parameter int MEM3_ADDR_WIDTH = 4,
  parameter int MEM3_SIZE       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       result_valid,
  input  logic [RESULT_WIDTH-1:0]    result_in,
  output logic                       result_ready,
  input  logic                       clear,
  input  logic                       read_en,
  input  logic [MEM3_ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0]      result_out,
  output logic                       writer_busy,
  output logic                       writer_done,
  output logic                       full,
  output logic [MEM3_ADDR_WIDTH-1:0] result_count
);
  localparam int NBYTES    = (RESULT_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int SHIFT_W   = NBYTES * DATA_WIDTH;
  localparam int IDX_W     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int PTR_W     = MEM3_ADDR_WIDTH + 1;
  localparam int MAX_COUNT = MEM3_SIZE / NBYTES;

  localparam logic [IDX_W-1:0]           LAST_IDX  = IDX_W'(NBYTES - 1);
  localparam logic [IDX_W-1:0]           IDX_ONE   = IDX_W'(1);
  localparam logic [PTR_W-1:0]           PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]           MEM_LIMIT = PTR_W'(MEM3_SIZE);
  localparam logic [MEM3_ADDR_WIDTH-1:0] CNT_ONE   = MEM3_ADDR_WIDTH'(1);
  localparam logic [MEM3_ADDR_WIDTH-1:0] CNT_MAX   = MEM3_ADDR_WIDTH'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                     state_q, state_d;
  logic [SHIFT_W-1:0]         shift_q, shift_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [MEM3_ADDR_WIDTH-1:0] count_q, count_d;
  logic                       full_q, full_d;
  logic [DATA_WIDTH-1:0]      result_out_q, result_out_d;
  logic                       ready_q, ready_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       mem_we;
  logic                       no_room;

  logic [DATA_WIDTH-1:0] mem3 [0:MEM3_SIZE-1];

  assign no_room = (32'(wr_ptr_q) + NBYTES) > MEM3_SIZE;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    full_d       = full_q;
    result_out_d = result_out_q;
    mem_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (result_valid && ready_q) begin
          shift_d = SHIFT_W'(result_in);
          idx_d   = '0;
          state_d = WRITE;
`ifdef DOT_WRITER_WRAP_EN
          if (no_room) wr_ptr_d = '0;
`endif
        end
      end
      WRITE: begin
        mem_we   = 1'b1;
        shift_d  = shift_q >> DATA_WIDTH;
        idx_d    = idx_q + IDX_ONE;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
`ifdef DOT_WRITER_WRAP_EN
        full_d = 1'b0;
`else
        full_d = no_room;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (read_en) begin
      if ({1'b0, read_addr} < MEM_LIMIT) result_out_d = mem3[read_addr];
      else                               result_out_d = '0;
    end

    // Clear (and reset) abort a write mid-result; bytes already stored are left in mem3.
    if (clear || rst) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      count_d  = '0;
      full_d   = 1'b0;
      mem_we   = 1'b0;
    end

    ready_d = (state_d == IDLE) && !full_d;
    busy_d  = (state_d == WRITE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      result_out_q <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      result_out_q <= result_out_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Result memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem3[wr_ptr_q[MEM3_ADDR_WIDTH-1:0]] <= shift_q[DATA_WIDTH-1:0];
  end

  assign result_ready = ready_q;
  assign result_out   = result_out_q;
  assign writer_busy  = busy_q;
  assign writer_done  = done_q;
  assign full         = full_q;
  assign result_count = count_q;

endmodule

// File: tb/tb_dot_result_writer.sv
// Self-checking bench for dot_result_writer; results are scoreboarded and read back byte-wise.
// Define DOT_WRITER_WRAP_EN for both files to exercise the wrap build.
module tb_dot_result_writer;
  logic        clk;
  logic        rst;
  logic        result_valid;
  logic [17:0] result_in;
  logic        result_ready;
  logic        clear;
  logic        read_en;
  logic [3:0]  read_addr;
  logic [7:0]  result_out;
  logic        writer_busy;
  logic        writer_done;
  logic        full;
  logic [3:0]  result_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          addr;
    logic [17:0] value;
  } sb_entry_t;
  sb_entry_t sb_q[$];

  dot_result_writer dut (
    .clk          (clk),
    .rst          (rst),
    .result_valid (result_valid),
    .result_in    (result_in),
    .result_ready (result_ready),
    .clear        (clear),
    .read_en      (read_en),
    .read_addr    (read_addr),
    .result_out   (result_out),
    .writer_busy  (writer_busy),
    .writer_done  (writer_done),
    .full         (full),
    .result_count (result_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_byte(input int addr, output logic [7:0] data);
    read_en   = 1'b1;
    read_addr = 4'(addr);
    tick();
    read_en   = 1'b0;
    data      = result_out;
  endtask

  // Presents one result, waits for acceptance, and checks the write timing around it.
  task automatic write_result(input logic [17:0] value, input int exp_addr);
    bit ok;
    int n;
    ok = 1'b0;
    result_valid = 1'b1;
    result_in    = value;
    for (int i = 0; i < 30; i++) begin
      if (result_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL accept_timeout value=%0h ready=%b required=1", value, result_ready);
      result_valid = 1'b0;
      return;
    end
    tick();
    result_valid = 1'b0;
    result_in    = '0;
    sb_q.push_back('{exp_addr, value});
    total++;
    if (writer_busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL busy_after_accept got=%b required=1", writer_busy);
    end
    n = 0;
    while (writer_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n !== 3) begin
      bad++;
      $display("[TB] FAIL done_latency got=%0d required=3", n);
    end
    tick();
    total++;
    if (writer_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL done_width got=%b required=0", writer_done);
    end
  endtask

  // Pops every expected result and reads its bytes back through the read port.
  task automatic check_scoreboard();
    sb_entry_t   e;
    logic [23:0] padded;
    logic [7:0]  data;
    logic [7:0]  exp_byte;
    while (sb_q.size() > 0) begin
      e      = sb_q.pop_front();
      padded = {6'b0, e.value};
      for (int k = 0; k < 3; k++) begin
        read_byte(e.addr + k, data);
        exp_byte = padded[8*k +: 8];
        total++;
        if (data !== exp_byte) begin
          bad++;
          $display("[TB] FAIL mem_byte addr=%0d got=%0h required=%0h", e.addr + k, data, exp_byte);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (result_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b required=1", result_ready); end
    total++; if (result_out !== 8'h00) begin bad++; $display("[TB] FAIL reset_result_out got=%0h required=0", result_out); end
    total++; if (writer_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b required=0", writer_busy); end
    total++; if (writer_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b required=0", writer_done); end
    total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got=%b required=0", full); end
    total++; if (result_count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d required=0", result_count); end
  endtask

  task automatic test_basic_write();
    logic [7:0] data;
    write_result(18'd10, 0);
    total++; if (result_count !== 4'd1) begin bad++; $display("[TB] FAIL basic_count got=%0d required=1", result_count); end
    check_scoreboard();
    read_byte(0, data);
    tick();
    tick();
    total++; if (result_out !== 8'h0A) begin bad++; $display("[TB] FAIL read_hold got=%0h required=0a", result_out); end
  endtask

  task automatic test_max_value();
    write_result(18'd260100, 3);
    total++; if (result_count !== 4'd2) begin bad++; $display("[TB] FAIL max_count got=%0d required=2", result_count); end
    check_scoreboard();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    result_valid = 1'b1;
    result_in    = 18'h2ABCD;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (result_ready === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL b2b_first_accept ready=%b required=1", result_ready);
    end
    tick();
    sb_q.push_back('{6, 18'h2ABCD});
    result_in = 18'h01234;
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ok = (result_ready === 1'b1);
      tick();
      n++;
      if (ok) break;
    end
    result_valid = 1'b0;
    result_in    = '0;
    total++;
    if (!ok || n !== 5) begin
      bad++;
      $display("[TB] FAIL b2b_spacing got=%0d required=5", n);
    end
    sb_q.push_back('{9, 18'h01234});
    n = 0;
    while (writer_done !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    tick();
    total++; if (result_count !== 4'd4) begin bad++; $display("[TB] FAIL b2b_count got=%0d required=4", result_count); end
    total++; if (result_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_idle_ready got=%b required=1", result_ready); end
    check_scoreboard();
  endtask

  task automatic fill_five();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (result_count !== 4'd0) begin bad++; $display("[TB] FAIL clear_count got=%0d required=0", result_count); end
    for (int i = 0; i < 5; i++) write_result(18'(i + 1), 3 * i);
    check_scoreboard();
    total++; if (result_count !== 4'd5) begin bad++; $display("[TB] FAIL five_count got=%0d required=5", result_count); end
  endtask

`ifndef DOT_WRITER_WRAP_EN
  task automatic test_full();
    bit leaked;
    int n;
    fill_five();
    total++; if (full !== 1'b1) begin bad++; $display("[TB] FAIL full_set got=%b required=1", full); end
    total++; if (result_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready got=%b required=0", result_ready); end
    result_valid = 1'b1;
    result_in    = 18'd6;
    leaked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (writer_busy !== 1'b0 || result_ready !== 1'b0) leaked = 1'b1;
    end
    total++; if (leaked) begin bad++; $display("[TB] FAIL full_blocks busy=%b ready=%b required=0", writer_busy, result_ready); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL clear_full got=%b required=0", full); end
    total++; if (result_ready !== 1'b1) begin bad++; $display("[TB] FAIL clear_ready got=%b required=1", result_ready); end
    tick();
    result_valid = 1'b0;
    result_in    = '0;
    sb_q.push_back('{0, 18'd6});
    n = 0;
    while (writer_done !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (n !== 3) begin bad++; $display("[TB] FAIL sixth_done_latency got=%0d required=3", n); end
    tick();
    total++; if (result_count !== 4'd1) begin bad++; $display("[TB] FAIL sixth_count got=%0d required=1", result_count); end
    check_scoreboard();
  endtask
`else
  task automatic test_wrap();
    fill_five();
    total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL wrap_full got=%b required=0", full); end
    total++; if (result_ready !== 1'b1) begin bad++; $display("[TB] FAIL wrap_ready got=%b required=1", result_ready); end
    write_result(18'h77, 0);
    total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL wrap_full_after got=%b required=0", full); end
    total++; if (result_count !== 4'd5) begin bad++; $display("[TB] FAIL wrap_count got=%0d required=5", result_count); end
    check_scoreboard();
  endtask
`endif

  task automatic test_reset_mid_write();
    bit pulsed;
    logic [7:0] data;
    result_valid = 1'b1;
    result_in    = 18'h00123;
    total++; if (result_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_ready_before got=%b required=1", result_ready); end
    tick();
    result_valid = 1'b0;
    result_in    = '0;
    read_en   = 1'b1;
    read_addr = 4'd3;
    tick();
    read_en = 1'b0;
    total++; if (result_out !== 8'h02) begin bad++; $display("[TB] FAIL read_before_write got=%0h required=02", result_out); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (writer_busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy got=%b required=0", writer_busy); end
    total++; if (result_count !== 4'd0) begin bad++; $display("[TB] FAIL mid_count got=%0d required=0", result_count); end
    total++; if (result_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_ready got=%b required=1", result_ready); end
    total++; if (result_out !== 8'h00) begin bad++; $display("[TB] FAIL mid_result_out got=%0h required=0", result_out); end
    pulsed = (writer_done !== 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (writer_done !== 1'b0) pulsed = 1'b1;
    end
    total++; if (pulsed) begin bad++; $display("[TB] FAIL mid_no_done got=1 required=0"); end
    read_byte(3, data);
    total++; if (data !== 8'h23) begin bad++; $display("[TB] FAIL mid_kept_byte got=%0h required=23", data); end
    read_byte(4, data);
    total++; if (data !== 8'h00) begin bad++; $display("[TB] FAIL mid_unwritten_byte got=%0h required=00", data); end
    write_result(18'h00055, 0);
    total++; if (result_count !== 4'd1) begin bad++; $display("[TB] FAIL post_rst_count got=%0d required=1", result_count); end
    check_scoreboard();
  endtask

  initial begin
    rst          = 1'b1;
    result_valid = 1'b0;
    result_in    = '0;
    clear        = 1'b0;
    read_en      = 1'b0;
    read_addr    = '0;
    test_reset();
    test_basic_write();
    test_max_value();
    test_back_to_back();
`ifndef DOT_WRITER_WRAP_EN
    test_full();
`else
    test_wrap();
`endif
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
